// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor computing A - B one bit per
// clock, LSB first, using a single full-subtractor cell and a borrow flop.
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   start       begin a subtraction (sampled only while idle)
//   A, B        minuend / subtrahend, captured on the accepting edge
//   busy        high while an operation is in flight (RUN or DONE)
//   done        one-cycle pulse; Diff/Borrow are valid in that cycle
//   Diff        registered result, (A - B) mod 2^WIDTH
//   Borrow      registered final borrow, 1 iff A < B (unsigned)
//   ser_diff    combinational difference bit of the current step (0 unless RUN)
//   ser_borrow  combinational borrow-out of the current step (0 unless RUN)
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             ser_diff,
    output logic             ser_borrow
);

    // Step counter needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               borrow_q, borrow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   res_shift;
    logic               last_step;

    // Full-subtractor cell on the operand LSBs and the running borrow.
    always_comb begin
        ser_diff   = 1'b0;
        ser_borrow = 1'b0;
        if (state_q == S_RUN) begin
            ser_diff   = a_q[0] ^ b_q[0] ^ br_q;
            ser_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        end
    end

    // New difference bit enters at the MSB, so after WIDTH steps bit i holds
    // step i. Written as shifts to stay valid for WIDTH=1.
    assign res_shift = (res_q >> 1) | (WIDTH'(ser_diff) << (WIDTH - 1));
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = ser_borrow;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    diff_d   = res_shift;
                    borrow_d = ser_borrow;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered copies of the next state.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Diff   = diff_q;
    assign Borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8): directed and random operations,
// expected results queued at issue time and compared by a done-driven monitor.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Borrow;
    logic         ser_diff;
    logic         ser_borrow;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .Diff       (Diff),
        .Borrow     (Borrow),
        .ser_diff   (ser_diff),
        .ser_borrow (ser_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec      = 0;
    int n_err      = 0;
    int done_seen  = 0;
    logic [W:0] exp_q[$];       // {borrow, diff}
    logic [W-1:0] last_d = '0;  // most recent completed result (model)
    logic         last_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Difference bit i of the arithmetic result.
    function automatic logic step_diff(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
        logic [W-1:0] d;
        d = a - b;
        return d[i];
    endfunction

    // Borrow out of bit i: the low i+1 bits of a are smaller than those of b.
    function automatic logic step_borrow(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
        int unsigned m;
        m = 32'(1) << (i + 1);
        return (int'(a) % m) < (int'(b) % m);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        logic [W:0] e;
        if (done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got Diff=%0h Borrow=%0b with no request outstanding", Diff, Borrow);
            end else begin
                e = exp_q.pop_front();
                check("result_diff", 32'(Diff), 32'(e[W-1:0]));
                check("result_borrow", 32'(Borrow), 32'(e[W]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and follow it to completion.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit intrude);
        logic [W-1:0] ed;
        logic         eb;
        int           edges;
        int           busyc;
        int           dbefore;
        ed = a - b;
        eb = (a < b);
        dbefore = done_seen;
        A = a;
        B = b;
        start = 1'b1;
        exp_q.push_back({eb, ed});
        tick();
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        edges = 0;
        busyc = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busyc++;
            if (edges < W) begin
                check("ser_diff", 32'(ser_diff), 32'(step_diff(a, b, edges)));
                check("ser_borrow", 32'(ser_borrow), 32'(step_borrow(a, b, edges)));
                check("hold_diff_run", 32'(Diff), 32'(last_d));
                check("hold_borrow_run", 32'(Borrow), 32'(last_b));
            end
            if (intrude && edges == 3) begin
                start = 1'b1;
                A = 8'hFF;
                B = 8'h00;
            end else if (intrude && edges == 4) begin
                start = 1'b0;
            end
            tick();
            edges++;
        end
        check("done_latency", 32'(edges), 32'(W));
        check("busy_cycles", 32'(busyc + int'(busy)), 32'(W + 1));
        check("ser_zero_done", 32'({ser_diff, ser_borrow}), 32'(0));
        last_d = ed;
        last_b = eb;
        tick();
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_done", 32'(done), 32'(0));
        check("idle_hold_diff", 32'(Diff), 32'(last_d));
        check("idle_hold_borrow", 32'(Borrow), 32'(last_b));
        check("done_pulse_count", 32'(done_seen - dbefore), 32'(1));
    endtask

    initial begin
        int t_done[$];
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_diff", 32'(Diff), 32'(0));
        check("rst_borrow", 32'(Borrow), 32'(0));
        check("rst_ser", 32'({ser_diff, ser_borrow}), 32'(0));
        rst = 1'b0;

        // Start on the first edge after reset release, then directed cases.
        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h05, 1'b0);
        run_op(8'h00, 8'hFF, 1'b0);
        run_op(8'hA5, 8'hA5, 1'b0);
        run_op(8'h10, 8'h01, 1'b1);
        check("ignored_start_busy", 32'(busy), 32'(0));

        // Abort mid-operation with reset during the 4th RUN cycle.
        A = 8'h37;
        B = 8'h12;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_diff", 32'(Diff), 32'(0));
        check("abort_borrow", 32'(Borrow), 32'(0));
        rst = 1'b0;
        last_d = '0;
        last_b = 1'b0;
        run_op(8'h80, 8'h01, 1'b0);

        // Start held high: back-to-back operations every W+2 cycles.
        A = 8'h09;
        B = 8'h04;
        start = 1'b1;
        repeat (3) exp_q.push_back({1'b0, 8'h05});
        cyc = 0;
        while (t_done.size() < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (done === 1'b1) t_done.push_back(cyc);
        end
        start = 1'b0;
        check("held_done_count", 32'(t_done.size()), 32'(3));
        if (t_done.size() == 3) begin
            check("held_first_latency", 32'(t_done[0]), 32'(W + 1));
            check("held_period_1", 32'(t_done[1] - t_done[0]), 32'(W + 2));
            check("held_period_2", 32'(t_done[2] - t_done[1]), 32'(W + 2));
        end
        last_d = 8'h05;
        last_b = 1'b0;
        repeat (2) tick();
        check("held_end_busy", 32'(busy), 32'(0));

        // Random operations with random idle gaps.
        for (int n = 0; n < 20; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                A = W'($urandom);
                B = W'($urandom);
                tick();
                check("gap_hold_diff", 32'(Diff), 32'(last_d));
                check("gap_busy", 32'(busy), 32'(0));
            end
            run_op(W'($urandom), W'($urandom), 1'b0);
        end

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
